flash_read_cache: RTL and testbench
===================================

Name: flash_read_cache

Overview:
- Direct-mapped, read-only word cache between the FemtoRV32 instruction/data read port (chip-select 0 region) and MappedSPIFlash.
- Hits return in one cycle without touching SPI. A miss issues one word fetch to MappedSPIFlash, fills the line and returns the word.
- Removes repeated SPI flash latency on loops executing from flash.

Parameters:
- ADDR_BITS, 20, word-address width (matches the flash map word_address[21:2]).
- INDEX_BITS, 4, log2 of line count (16 lines, 1 word per line).
- CNT_BITS, 16, width of the hit/miss statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rstrb  in  1  CPU read strobe (cs[0] & rd), one-cycle pulse.
- word_address  in  ADDR_BITS  CPU word address.
- rdata  out  32  read data to CPU read mux.
- rbusy  out  1  CPU read-busy, ORed into mem_rbusy.
- flush  in  1  invalidate all lines (single-cycle pulse).
- flash_rstrb  out  1  read strobe to MappedSPIFlash.
- flash_word_address  out  ADDR_BITS  address to MappedSPIFlash.
- flash_rdata  in  32  data from MappedSPIFlash.
- flash_rbusy  in  1  busy from MappedSPIFlash.
- hit_count  out  CNT_BITS  saturating hit counter.
- miss_count  out  CNT_BITS  saturating miss counter.

Behaviour:
- Reset (async, rst=1):
  - All valid bits cleared; state IDLE.
  - rdata=0, rbusy=0, flash_rstrb=0, flash_word_address=0, hit_count=0, miss_count=0.
- Address split:
  - index = word_address[INDEX_BITS-1:0].
  - tag = word_address[ADDR_BITS-1:INDEX_BITS].
  - Tag, data and valid arrays are flop-based with combinational read.
- FSM states: IDLE, FILL_REQ, FILL_WAIT.
- rbusy = (state != IDLE), combinational from the state register.
- Hit (IDLE, rstrb=1 in cycle T, valid & tag match):
  - rdata is registered with the line data at the end of T.
  - rbusy stays 0. Data is valid at T+1 and held until the next completed read.
  - hit_count increments.
- Miss (IDLE, rstrb=1 in cycle T, no match):
  - Address is latched; next state FILL_REQ; miss_count increments.
- FILL_REQ (T+1):
  - flash_rstrb=1 for exactly this cycle, flash_word_address = latched address.
  - rbusy=1; next state FILL_WAIT.
- FILL_WAIT:
  - flash_rbusy is ignored in the first FILL_WAIT cycle (MappedSPIFlash raises busy one cycle after its strobe).
  - From the second cycle onward, flash_rbusy=0 in cycle F completes the fill: line data/tag written, valid set, rdata=flash_rdata, state IDLE.
  - rbusy=0 at F+1.
- Latency:
  - Hit: 1 cycle.
  - Miss: flash latency + 2 cycles.
- flash_word_address holds its last value outside FILL_REQ; flash_rstrb=0 outside FILL_REQ.
- rstrb while not IDLE: ignored (the CPU never issues one). No counter change.
- flush:
  - In IDLE: all valid bits cleared next edge.
  - Coinciding with a hit strobe: the hit is served, then lines are invalidated.
  - During FILL_REQ/FILL_WAIT: the fill completes and the word is returned, but the filled line is left invalid. Use a sticky "flush_pending" flag cleared on return to IDLE.
- Counters saturate at all-ones; only rst clears them.
- Reset mid-fill: FSM returns to IDLE immediately and rbusy drops. A late flash completion is ignored (state is IDLE).

Decomposition:
- Shared package (flash_cache_pkg):
  - state encoding constants (IDLE=0, FILL_REQ=1, FILL_WAIT=2).
  - default ADDR_BITS/INDEX_BITS/CNT_BITS.
- One natural sub-module: sat_counter (CNT_BITS-wide saturating incrementer with enable), instantiated twice.
- Arrays stay inline.

Test Plan:
- Reset, then read 0x00010 with a flash model of latency 20 returning 0xDEADBEEF:
  - rbusy=1 from T+1; flash_rstrb single pulse at T+1 with address 0x00010.
  - rdata=0xDEADBEEF and rbusy=0 at F+1.
  - miss_count=1.
- Repeat read of 0x00010:
  - rbusy never rises, no flash_rstrb, rdata=0xDEADBEEF at T+1, hit_count=1.
- Conflict: read 0x00010, then 0x00020 (same index 0, different tag), then 0x00010:
  - three misses, flash_rstrb pulsed three times, data correct each time.
- flush pulse during FILL_WAIT of 0x00031:
  - data still returned.
  - Subsequent read of 0x00031 misses (miss_count +1).
- Assert rst mid-FILL_WAIT:
  - rbusy=0 and all counters 0 immediately.
  - The prior hit address now misses.
- Saturation (force CNT_BITS=4): 20 hits to one address → hit_count stays 0xF.

Source files
------------

// File: rtl/flash_cache_pkg.sv
//==============================================================================
// flash_cache_pkg : shared constants for the flash read cache
// Rev 1.0
//==============================================================================
`default_nettype none

package flash_cache_pkg;

  localparam int c_ADDR_BITS  = 20;
  localparam int c_INDEX_BITS = 4;
  localparam int c_CNT_BITS   = 16;

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_FILL_REQ  = 2'd1;
  localparam logic [1:0] c_FILL_WAIT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/flash_read_cache_sat_counter.sv
//==============================================================================
// sat_counter : WIDTH-bit incrementer that sticks at all-ones
// Rev 1.0
//==============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_read_cache.sv
//==============================================================================
// flash_read_cache : direct-mapped one-word-per-line read cache for SPI flash
// Rev 1.0
//==============================================================================
`default_nettype none

module flash_read_cache
  import flash_cache_pkg::*;
#(
  parameter int ADDR_BITS  = c_ADDR_BITS,
  parameter int INDEX_BITS = c_INDEX_BITS,
  parameter int CNT_BITS   = c_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rstrb,
  input  logic [ADDR_BITS-1:0] word_address,
  output logic [31:0]          rdata,
  output logic                 rbusy,
  input  logic                 flush,
  output logic                 flash_rstrb,
  output logic [ADDR_BITS-1:0] flash_word_address,
  input  logic [31:0]          flash_rdata,
  input  logic                 flash_rbusy,
  output logic [CNT_BITS-1:0]  hit_count,
  output logic [CNT_BITS-1:0]  miss_count
);

  localparam int c_LINES    = 1 << INDEX_BITS;
  localparam int c_TAG_BITS = ADDR_BITS - INDEX_BITS;

  logic [1:0]            r_state;
  logic                  r_wait_first;
  logic                  r_flush_pending;
  logic [c_LINES-1:0]    r_valid;
  logic [c_TAG_BITS-1:0] r_tag  [c_LINES];
  logic [31:0]           r_data [c_LINES];

  logic [INDEX_BITS-1:0] w_index;
  logic [c_TAG_BITS-1:0] w_tag;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [c_TAG_BITS-1:0] w_fill_tag;
  logic                  w_idle;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_fill_done;

  assign w_index      = word_address[INDEX_BITS-1:0];
  assign w_tag        = word_address[ADDR_BITS-1:INDEX_BITS];
  assign w_fill_index = flash_word_address[INDEX_BITS-1:0];
  assign w_fill_tag   = flash_word_address[ADDR_BITS-1:INDEX_BITS];

  assign w_idle      = (r_state == c_IDLE);
  assign w_hit       = w_idle && rstrb && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss      = w_idle && rstrb && !w_hit;
  // Busy is only trusted from the second wait cycle; the flash raises it late.
  assign w_fill_done = (r_state == c_FILL_WAIT) && !r_wait_first && !flash_rbusy;

  assign rbusy       = !w_idle;
  assign flash_rstrb = (r_state == c_FILL_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= c_IDLE;
      r_wait_first       <= 1'b0;
      r_flush_pending    <= 1'b0;
      r_valid            <= '0;
      rdata              <= '0;
      flash_word_address <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hit) begin
            rdata <= r_data[w_index];
          end else if (w_miss) begin
            flash_word_address <= word_address;
            r_state            <= c_FILL_REQ;
          end
        end
        c_FILL_REQ: begin
          r_wait_first <= 1'b1;
          r_state      <= c_FILL_WAIT;
        end
        c_FILL_WAIT: begin
          r_wait_first <= 1'b0;
          if (w_fill_done) begin
            rdata   <= flash_rdata;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase

      // A flush seen at any point of a fill keeps the filled line invalid.
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill_done && !r_flush_pending) begin
        r_valid[w_fill_index] <= 1'b1;
      end

      if (w_fill_done) begin
        r_flush_pending <= 1'b0;
      end else if (flush && !w_idle) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= flash_rdata;
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_hit),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_BITS)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_miss),
    .count (miss_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_flash_read_cache.sv
//==============================================================================
// tb_flash_read_cache : random reads against a behavioural cache/flash model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_flash_read_cache;

  localparam int AB = 20;
  localparam int IB = 4;
  localparam int CB = 4;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rstrb = 1'b0;
  logic          flush = 1'b0;
  logic [AB-1:0] word_address = '0;
  logic [31:0]   rdata;
  logic          rbusy;
  logic          flash_rstrb;
  logic [AB-1:0] flash_word_address;
  logic [31:0]   flash_rdata = '0;
  logic          flash_rbusy = 1'b0;
  logic [CB-1:0] hit_count;
  logic [CB-1:0] miss_count;

  flash_read_cache #(.ADDR_BITS(AB), .INDEX_BITS(IB), .CNT_BITS(CB)) dut (
    .clk                (clk),
    .rst                (rst),
    .rstrb              (rstrb),
    .word_address       (word_address),
    .rdata              (rdata),
    .rbusy              (rbusy),
    .flush              (flush),
    .flash_rstrb        (flash_rstrb),
    .flash_word_address (flash_word_address),
    .flash_rdata        (flash_rdata),
    .flash_rbusy        (flash_rbusy),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
    if (a == 20'h00010) return 32'hDEADBEEF;
    return {a[11:0], a} ^ 32'hA5C3_0F69;
  endfunction

  // Flash model: optional dead cycle after the strobe, then busy for cur_lat cycles.
  int            cur_lat = 20;
  bit            cur_gap = 1'b0;
  int            fl_cnt = 0;
  bit            fl_gap = 1'b0;
  logic [AB-1:0] fl_addr = '0;
  int            pulses = 0;

  always @(posedge clk) begin
    if (flash_rstrb) begin
      fl_cnt      <= cur_lat;
      fl_gap      <= cur_gap;
      flash_rbusy <= !cur_gap;
      fl_addr     <= flash_word_address;
    end else if (fl_gap) begin
      fl_gap      <= 1'b0;
      flash_rbusy <= 1'b1;
    end else if (fl_cnt > 1) begin
      fl_cnt <= fl_cnt - 1;
    end else if (fl_cnt == 1) begin
      fl_cnt      <= 0;
      flash_rbusy <= 1'b0;
      flash_rdata <= mem_word(fl_addr);
    end
  end

  // Behavioural model of what the CPU side must see.
  bit            mv [16];
  logic [15:0]   mt [16];
  logic [31:0]   md [16];
  logic          m_rbusy  = 1'b0;
  logic          m_fstrb  = 1'b0;
  logic [AB-1:0] m_faddr  = '0;
  logic [31:0]   m_rdata  = '0;
  int            m_hits   = 0;
  int            m_misses = 0;

  always @(negedge clk) begin
    check("rbusy", 32'(rbusy), 32'(m_rbusy));
    check("flash_rstrb", 32'(flash_rstrb), 32'(m_fstrb));
    if (m_fstrb) check("flash_word_address", 32'(flash_word_address), 32'(m_faddr));
    check("rdata", rdata, m_rdata);
    check("hit_count", 32'(hit_count), 32'(m_hits));
    check("miss_count", 32'(miss_count), 32'(m_misses));
    if (flash_rstrb) pulses++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Called at posedge+2 of an idle cycle; returns at posedge+2 of the first idle cycle after.
  task automatic do_read(input logic [AB-1:0] a, input int lat, input bit gap,
                         input int flush_k, input bit flush_with);
    int          idx;
    logic [15:0] tg;
    bit          hit;
    bit          pend;
    idx  = int'(a[3:0]);
    tg   = a[19:4];
    hit  = mv[idx] && (mt[idx] == tg);
    pend = 1'b0;
    cur_lat = lat;
    cur_gap = gap;
    word_address = a;
    rstrb = 1'b1;
    flush = flush_with;
    step();
    rstrb = 1'b0;
    flush = 1'b0;
    if (hit) begin
      m_rdata = md[idx];
      if (m_hits < CNT_MAX) m_hits++;
      if (flush_with) clear_model();
    end else begin
      if (m_misses < CNT_MAX) m_misses++;
      m_rbusy = 1'b1;
      m_fstrb = 1'b1;
      m_faddr = a;
      for (int k = 1; k <= lat + 2 + int'(gap); k++) begin
        if (k == 2) m_fstrb = 1'b0;
        if (k == flush_k) begin
          flush = 1'b1;
          pend  = 1'b1;
          clear_model();
        end else begin
          flush = 1'b0;
        end
        step();
      end
      flush   = 1'b0;
      m_rbusy = 1'b0;
      m_rdata = mem_word(a);
      if (!pend) begin
        mv[idx] = 1'b1;
        mt[idx] = tg;
        md[idx] = mem_word(a);
      end
    end
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    clear_model();
    step();
    flush = 1'b0;
  endtask

  initial begin
    int p0;
    int mc0;
    logic [AB-1:0] a;
    int lat;
    bit gap;
    int fk;
    clear_model();
    repeat (3) step();
    check("reset_rdata", rdata, 32'h0);
    check("reset_flash_addr", 32'(flash_word_address), 32'h0);
    rst = 1'b0;
    step();

    // First miss with a slow flash
    p0 = pulses;
    do_read(20'h00010, 20, 1'b0, 0, 1'b0);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_miss_count", 32'(miss_count), 32'd1);
    check("t1_pulses", 32'(pulses - p0), 32'd1);

    // Repeat read hits without touching flash
    p0 = pulses;
    do_read(20'h00010, 20, 1'b0, 0, 1'b0);
    check("t2_rdata", rdata, 32'hDEADBEEF);
    check("t2_hit_count", 32'(hit_count), 32'd1);
    check("t2_pulses", 32'(pulses - p0), 32'd0);

    // Same index, alternating tags: every access misses
    p0 = pulses;
    do_read(20'h00020, 3, 1'b1, 0, 1'b0);
    do_read(20'h00010, 2, 1'b0, 0, 1'b0);
    check("t3_rdata_10", rdata, 32'hDEADBEEF);
    do_read(20'h00020, 4, 1'b0, 0, 1'b0);
    check("t3_pulses", 32'(pulses - p0), 32'd3);
    check("t3_miss_count", 32'(miss_count), 32'd4);

    // Flush during FILL_WAIT: data returned, line stays invalid
    do_read(20'h00031, 8, 1'b0, 5, 1'b0);
    mc0 = int'(miss_count);
    do_read(20'h00031, 3, 1'b0, 0, 1'b0);
    check("t4_remiss", 32'(miss_count), 32'(mc0 + 1));

    // Flush coinciding with a hit: hit served, then invalidated
    do_read(20'h00031, 3, 1'b0, 0, 1'b1);
    do_read(20'h00031, 2, 1'b0, 0, 1'b0);
    idle_flush();
    do_read(20'h00031, 2, 1'b1, 0, 1'b0);

    // Reset in the middle of a fill
    do_read(20'h00010, 2, 1'b0, 0, 1'b0);
    word_address = 20'h00055;
    cur_lat = 10;
    cur_gap = 1'b0;
    rstrb = 1'b1;
    step();
    rstrb = 1'b0;
    m_misses = (m_misses < CNT_MAX) ? m_misses + 1 : m_misses;
    m_rbusy = 1'b1; m_fstrb = 1'b1; m_faddr = 20'h00055;
    step();
    m_fstrb = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    m_rbusy = 1'b0; m_rdata = '0; m_hits = 0; m_misses = 0;
    clear_model();
    #1;
    check("t5_rbusy", 32'(rbusy), 32'd0);
    check("t5_hit_count", 32'(hit_count), 32'd0);
    check("t5_miss_count", 32'(miss_count), 32'd0);
    step();
    rst = 1'b0;
    repeat (14) step();
    do_read(20'h00010, 2, 1'b0, 0, 1'b0);
    check("t5_prior_hit_misses", 32'(miss_count), 32'd1);

    // Hit counter saturation
    for (int i = 0; i < 20; i++) do_read(20'h00010, 2, 1'b0, 0, 1'b0);
    check("t6_hit_sat", 32'(hit_count), 32'hF);

    // Random traffic over a small address pool
    for (int n = 0; n < 120; n++) begin
      a   = AB'({$urandom_range(0, 3), 4'(0)}) | AB'($urandom_range(0, 3));
      lat = int'($urandom_range(1, 6));
      gap = 1'($urandom_range(0, 1));
      fk  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lat + 2 + int'(gap))) : 0;
      do_read(a, lat, gap, fk, 1'b0);
      repeat ($urandom_range(0, 2)) step();
      if ($urandom_range(0, 11) == 0) idle_flush();
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
